// File: rtl/tile_sequencer_pkg.sv
// Shared definitions for the tile sequencer and the datapath blocks it drives:
// top-level state codes and default tile geometry.
package tile_sequencer_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TM      = 4;
    localparam int unsigned TN      = 16;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned NUM_D_W = 4;

    // Codes are fixed; loaders and PE array decode top_level_state directly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_F  = 3'd1,
        ST_LOAD_W  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WRITEB  = 3'd4,
        ST_DONE    = 3'd5,
        ST_CLR_W   = 3'd6
    } state_e;

endpackage

// File: rtl/tile_sequencer.sv
// Layer-level sequencer: walks output/input channel tiles through feature load,
// weight clear/load, compute and writeback, broadcasting the phase as a state code.
module tile_sequencer #(
    parameter int unsigned CNT_W = tile_sequencer_pkg::CNT_W,
    parameter int unsigned TM    = tile_sequencer_pkg::TM,
    parameter int unsigned TN    = tile_sequencer_pkg::TN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_m_last,
    input  logic [CNT_W-1:0] cfg_n_last,
    input  logic [3:0]       cfg_num_d,
    input  logic             fl_done,
    input  logic             wl_finish_flg,
    input  logic             pe_done,
    input  logic             wb_done,
    output logic [2:0]       top_level_state,
    output logic [3:0]       num_d,
    output logic             wl_rst,
    output logic             acc_first,
    output logic [CNT_W-1:0] m_idx,
    output logic [CNT_W-1:0] n_idx,
    output logic             busy,
    output logic             layer_done
);

    import tile_sequencer_pkg::*;

    // Tile geometry is only consumed downstream; reject degenerate builds early.
    if (TM == 0 || TN == 0) begin : g_bad_tile
        $error("tile_sequencer: TM and TN must be non-zero");
    end

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   m_last;
    logic [CNT_W-1:0]   n_last;
    logic [CNT_W-1:0]   m_last_nxt;
    logic [CNT_W-1:0]   n_last_nxt;
    logic [CNT_W-1:0]   m_nxt;
    logic [CNT_W-1:0]   n_nxt;
    logic [NUM_D_W-1:0] num_d_nxt;
    logic               wl_rst_nxt;
    logic               acc_first_nxt;
    logic               busy_nxt;
    logic               layer_done_nxt;

    assign top_level_state = state;

    // State, latched config, indices and phase flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            m_last     <= '0;
            n_last     <= '0;
            num_d      <= '0;
            m_idx      <= '0;
            n_idx      <= '0;
            wl_rst     <= 1'b0;
            acc_first  <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            m_last     <= m_last_nxt;
            n_last     <= n_last_nxt;
            num_d      <= num_d_nxt;
            m_idx      <= m_nxt;
            n_idx      <= n_nxt;
            wl_rst     <= wl_rst_nxt;
            acc_first  <= acc_first_nxt;
            busy       <= busy_nxt;
            layer_done <= layer_done_nxt;
        end
    end

    // Next state; done pulses are only looked at in their own phase.
    always_comb begin
        state_nxt  = state;
        m_last_nxt = m_last;
        n_last_nxt = n_last;
        num_d_nxt  = num_d;
        m_nxt      = m_idx;
        n_nxt      = n_idx;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    m_last_nxt = cfg_m_last;
                    n_last_nxt = cfg_n_last;
                    num_d_nxt  = cfg_num_d;
                    m_nxt      = '0;
                    n_nxt      = '0;
                    state_nxt  = ST_LOAD_F;
                end
            end
            ST_LOAD_F: begin
                if (fl_done) begin
                    state_nxt = ST_CLR_W;
                end
            end
            ST_CLR_W: begin
                state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                if (wl_finish_flg) begin
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (pe_done) begin
                    if (n_idx == n_last) begin
                        n_nxt     = '0;
                        state_nxt = ST_WRITEB;
                    end else begin
                        n_nxt     = n_idx + CNT_W'(1);
                        state_nxt = ST_LOAD_F;
                    end
                end
            end
            ST_WRITEB: begin
                if (wb_done) begin
                    if (m_idx == m_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        m_nxt     = m_idx + CNT_W'(1);
                        state_nxt = ST_LOAD_F;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Flags are registered alongside the state they describe.
        wl_rst_nxt     = (state_nxt == ST_CLR_W);
        acc_first_nxt  = (state_nxt == ST_COMPUTE) && (n_nxt == '0);
        busy_nxt       = (state_nxt != ST_IDLE);
        layer_done_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameters: CNT_W, default 8, tile-index width; TM, default 4, output channels per tile; TN, default 16, input channels per tile.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin layer; honoured only in IDLE.
REQ-005 cfg_m_last  input  CNT_W  output-channel tile count minus 1.
REQ-006 cfg_n_last  input  CNT_W  input-channel tile count minus 1.
REQ-007 cfg_num_d  input  4  weight beats per load minus 1.
REQ-008 fl_done  input  1  feature-load complete pulse.
REQ-009 wl_finish_flg  input  1  weight-load complete (sticky until weight loader reset).
REQ-010 pe_done  input  1  compute complete pulse.
REQ-011 wb_done  input  1  writeback complete pulse.
REQ-012 top_level_state  output  3  current state code; drives all datapath blocks.
REQ-013 num_d  output  4  latched cfg_num_d.
REQ-014 wl_rst  output  1  weight-loader reset, high only in CLR_W.
REQ-015 acc_first  output  1  high in COMPUTE when n_idx==0 (PE overwrites rather than accumulates).
REQ-016 m_idx, n_idx  output  CNT_W each  current tile indices.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 layer_done  output  1  one-cycle pulse, high only in DONE.

Function
REQ-019 State codes, fixed: IDLE=0, LOAD_F=1, LOAD_W=2, COMPUTE=3, WRITEB=4, DONE=5, CLR_W=6; code 7 unused, returns to IDLE next cycle.
REQ-020 top_level_state, wl_rst, acc_first, busy and layer_done are registered or decoded from the state register only; no combinational path from any input to any output.
REQ-021 IDLE & start: latch cfg_m_last, cfg_n_last, cfg_num_d; clear m_idx, n_idx; go to LOAD_F next cycle.
REQ-022 Config inputs changing outside the start cycle have no effect until the next layer.
REQ-023 LOAD_F & fl_done -> CLR_W; CLR_W -> LOAD_W unconditionally after exactly 1 cycle.
REQ-024 LOAD_W & wl_finish_flg -> COMPUTE; wl_finish_flg is ignored in every other state, including a stale high during CLR_W.
REQ-025 COMPUTE & pe_done: if n_idx==n_last, clear n_idx and go to WRITEB; else increment n_idx and go to LOAD_F.
REQ-026 WRITEB & wb_done: if m_idx==m_last, go to DONE; else increment m_idx and go to LOAD_F.
REQ-027 DONE -> IDLE after 1 cycle; m_idx and n_idx hold their final values until the next start.
REQ-028 Done pulses not matching the current state are dropped, not queued.
REQ-029 start while busy is ignored.
REQ-030 Index arithmetic is unsigned CNT_W bits; m_last = n_last = 0 yields exactly one pass of each phase.
REQ-031 Total phases per layer: (m_last+1)*(n_last+1) LOAD_F/CLR_W/LOAD_W/COMPUTE passes and m_last+1 WRITEB passes.

Reset
REQ-032 rst outputs, synchronous: top_level_state=0 (IDLE), num_d=0, wl_rst=0, acc_first=0, m_idx=0, n_idx=0, busy=0, layer_done=0.
REQ-033 rst mid-layer aborts immediately with no layer_done pulse; latched config is cleared to 0.
REQ-034 rst has priority over start in the same cycle.

Structure
REQ-035 A shared package holds the state-code constants (REQ-019), TM, TN and CNT_W; weight loader, feature loader and PE array import the same codes.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 m_last=0, n_last=0, start, then fl_done, wl_finish_flg and pe_done each 3 cycles after phase entry, then wb_done -> states 1,6,2,3,4,5,0; one layer_done pulse; wl_rst high exactly 1 cycle.
REQ-038 m_last=1, n_last=2 -> 6 COMPUTE passes; acc_first high on passes with n_idx=0 only; 2 WRITEB passes; final m_idx=1, n_idx=0.
REQ-039 wl_finish_flg held high from before start -> state stays in CLR_W for 1 cycle, then enters LOAD_W and moves to COMPUTE on the following cycle only.
REQ-040 pe_done pulse during LOAD_F and start pulse during COMPUTE -> both ignored; state and indices unchanged.
REQ-041 rst asserted during the second COMPUTE of REQ-038 -> next cycle all outputs at REQ-032 values, no layer_done; a fresh start runs a full layer correctly.
REQ-042 cfg_m_last changed from 1 to 3 mid-layer -> layer still ends after 2 WRITEB passes.
